// File: rtl/dl_rom_wide.sv
// ROM region with an ioctl download loader: packs HPS bytes into DATA_WIDTH words.
// Optional DL_ROM_CHECKSUM_EN adds a 16-bit sum of accepted bytes.
module dl_rom_wide #(
  parameter int          ADDR_WIDTH = 14,
  parameter int          DATA_WIDTH = 8,
  parameter logic [24:0] BASE_ADDR  = 25'h0,
  parameter logic [7:0]  INDEX      = 8'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic                  ce_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  loaded
`ifdef DL_ROM_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int LANE_SH = $clog2(BYTES);
  localparam int LANE_W  = (LANE_SH > 0) ? LANE_SH : 1;
  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t                  state_reg;
  logic                    dl_prev_reg;
  logic [DATA_WIDTH-1:0]   lane_buf_reg;
  logic [BYTES-1:0]        mask_reg;
  logic [ADDR_WIDTH-1:0]   word_reg;
  logic                    close_reg;

  logic [24:0]             off;
  logic [LANE_W-1:0]       lane;
  logic [ADDR_WIDTH-1:0]   word;
  logic [BYTES-1:0]        lane_hit;
  logic                    in_range;
  logic                    index_match;
  logic                    accept;
  logic                    dl_start;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    ce_reg;

  // Offset is only meaningful once ioctl_addr >= BASE_ADDR; the upper bits
  // beyond word+lane must then be zero for the byte to fall in this region.
  assign off         = ioctl_addr - BASE_ADDR;
  assign in_range    = (ioctl_addr >= BASE_ADDR) && ((off >> (LANE_SH + ADDR_WIDTH)) == 25'd0);
  assign index_match = (ioctl_index == INDEX);
  assign accept      = ioctl_wr && ioctl_download && index_match && in_range;
  assign dl_start    = ioctl_download && !dl_prev_reg && index_match;
  assign word        = off[LANE_SH +: ADDR_WIDTH];

  generate
    if (LANE_SH > 0) begin : g_lane
      assign lane = off[LANE_W-1:0];
    end else begin : g_no_lane
      assign lane = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lanes
      assign lane_hit[gi]         = (lane == LANE_W'(gi));
      assign wr_data[8*gi +: 8]   = mask_reg[gi] ? lane_buf_reg[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // One write per cycle: a closed word, a held word displaced by a new word
  // index, or the final partial word while flushing.
  assign wr_en = (mask_reg != '0) &&
                 (close_reg || (accept && (word != word_reg)) || (state_reg == FLUSH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      loaded      <= 1'b0;
      dl_prev_reg <= 1'b0;
    end else begin
      dl_prev_reg <= ioctl_download;
      case (state_reg)
        IDLE: begin
          if (dl_start) begin
            state_reg <= LOAD;
            loaded    <= 1'b0;
          end
        end
        LOAD: begin
          if (!ioctl_download) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          state_reg <= DONE;
          loaded    <= 1'b1;
        end
        DONE: begin
          if (dl_start) begin
            state_reg <= LOAD;
            loaded    <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          loaded    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_buf_reg <= '0;
      mask_reg     <= '0;
      word_reg     <= '0;
      close_reg    <= 1'b0;
    end else begin
      close_reg <= accept && (lane == LAST_LANE);
      for (int i = 0; i < BYTES; i++) begin
        if (accept && lane_hit[i]) begin
          lane_buf_reg[8*i +: 8] <= ioctl_dout;
        end
      end
      if (accept) begin
        mask_reg <= (wr_en ? '0 : mask_reg) | lane_hit;
        word_reg <= word;
      end else if (wr_en) begin
        mask_reg <= '0;
      end
    end
  end

`ifdef DL_ROM_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= 16'h0000;
    end else if (((state_reg == IDLE) || (state_reg == DONE)) && dl_start) begin
      checksum <= accept ? {8'h00, ioctl_dout} : 16'h0000;
    end else if (accept && (state_reg != DONE)) begin
      checksum <= checksum + {8'h00, ioctl_dout};
    end
  end
`endif

  // Read-first block RAM: a same-cycle write to the read word returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_reg] <= wr_data;
    end
    data_reg <= mem[addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_reg <= 1'b0;
    end else begin
      ce_reg <= ~ce_n;
    end
  end

  assign q = ce_reg ? data_reg : '0;

endmodule

// File: tb/tb_dl_rom_wide.sv
// Bench for dl_rom_wide: three regions (16/32/8-bit words) share one ioctl bus
// and are checked against a byte-level model of the download rules.
module tb_dl_rom_wide;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ce_n;
  logic [5:0]  addr;
  logic [15:0] q16;
  logic [31:0] q32;
  logic [7:0]  q8;
  logic        loaded16, loaded32, loaded8;
`ifdef DL_ROM_CHECKSUM_EN
  logic [15:0] cs16, cs32, cs8;
`endif

  always #5 clk = ~clk;

  dl_rom_wide #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .BASE_ADDR(25'h100), .INDEX(8'd1)) u16 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ce_n(ce_n), .addr(addr), .q(q16), .loaded(loaded16)
`ifdef DL_ROM_CHECKSUM_EN
    , .checksum(cs16)
`endif
  );

  dl_rom_wide #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BASE_ADDR(25'h400), .INDEX(8'd2)) u32 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ce_n(ce_n), .addr(addr), .q(q32), .loaded(loaded32)
`ifdef DL_ROM_CHECKSUM_EN
    , .checksum(cs32)
`endif
  );

  dl_rom_wide #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .BASE_ADDR(25'h800), .INDEX(8'd3)) u8 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ce_n(ce_n), .addr(addr), .q(q8), .loaded(loaded8)
`ifdef DL_ROM_CHECKSUM_EN
    , .checksum(cs8)
`endif
  );

  // Reference model: per region, a word memory with known flags, the bytes of
  // the word currently being assembled, the loaded flag and the byte sum.
  int          n_checks = 0;
  int          n_fail   = 0;
  int          base_m [3] = '{32'h100, 32'h400, 32'h800};
  int          bytes_m[3] = '{2, 4, 1};
  int          idx_m  [3] = '{1, 2, 3};
  logic [31:0] mm [3][64];
  bit          mk [3][64];
  int          hw [3];
  logic [7:0]  hb [3][4];
  bit          hv [3][4];
  bit          ld_m [3];
  bit          inload [3];
  int          cs_m [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_commit(int d);
    logic [31:0] w;
    bit any;
    w = 0;
    any = 0;
    for (int l = 0; l < 4; l++) begin
      if (hv[d][l]) begin
        w = w | (32'(hb[d][l]) << (8 * l));
        any = 1;
      end
      hv[d][l] = 0;
    end
    if (any) begin
      mm[d][hw[d]] = w;
      mk[d][hw[d]] = 1;
    end
  endfunction

  function automatic bit m_held(int d);
    return hv[d][0] | hv[d][1] | hv[d][2] | hv[d][3];
  endfunction

  function automatic void m_byte(int idx, int a, int v);
    int off, lane, word;
    for (int d = 0; d < 3; d++) begin
      if (idx == idx_m[d] && a >= base_m[d] && a < base_m[d] + bytes_m[d] * 64) begin
        off  = a - base_m[d];
        lane = off % bytes_m[d];
        word = off / bytes_m[d];
        if (m_held(d) && word != hw[d]) m_commit(d);
        hw[d] = word;
        hb[d][lane] = 8'(v);
        hv[d][lane] = 1;
        cs_m[d] = (cs_m[d] + v) % 65536;
        if (lane == bytes_m[d] - 1) m_commit(d);
      end
    end
  endfunction

  function automatic void m_start(int idx);
    for (int d = 0; d < 3; d++) begin
      if (idx == idx_m[d]) begin
        ld_m[d] = 0;
        inload[d] = 1;
        cs_m[d] = 0;
      end
    end
  endfunction

  function automatic void m_end();
    for (int d = 0; d < 3; d++) begin
      if (inload[d]) begin
        m_commit(d);
        ld_m[d] = 1;
        inload[d] = 0;
      end
    end
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 3; d++) begin
      for (int l = 0; l < 4; l++) hv[d][l] = 0;
      ld_m[d] = 0;
      inload[d] = 0;
      cs_m[d] = 0;
    end
  endfunction

  function automatic logic [31:0] q_of(int d);
    case (d)
      0:       return {16'h0000, q16};
      1:       return q32;
      default: return {24'h000000, q8};
    endcase
  endfunction

  function automatic logic loaded_of(int d);
    case (d)
      0:       return loaded16;
      1:       return loaded32;
      default: return loaded8;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl(input int idx);
    ioctl_index = 8'(idx);
    ioctl_download = 1'b1;
    m_start(idx);
    tick();
  endtask

  task automatic wr_byte(input int a, input int v);
    ioctl_addr = 25'(a);
    ioctl_dout = 8'(v);
    ioctl_wr = 1'b1;
    m_byte(int'(ioctl_index), a, v);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    m_end();
    repeat (4) tick();
  endtask

  task automatic check_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s loaded d%0d", tag, d), 32'(loaded_of(d)), 32'(ld_m[d]));
    end
`ifdef DL_ROM_CHECKSUM_EN
    check($sformatf("%s checksum d0", tag), 32'(cs16), 32'(cs_m[0]));
    check($sformatf("%s checksum d1", tag), 32'(cs32), 32'(cs_m[1]));
    check($sformatf("%s checksum d2", tag), 32'(cs8),  32'(cs_m[2]));
`endif
  endtask

  task automatic sweep(input string tag);
    bit en;
    for (int w = 0; w < 64; w++) begin
      en = ($urandom_range(0, 3) != 0);
      addr = 6'(w);
      ce_n = ~en;
      tick();
      for (int d = 0; d < 3; d++) begin
        if (!en) check($sformatf("%s off d%0d w%0d", tag, d, w), q_of(d), 32'h0);
        else if (mk[d][w]) check($sformatf("%s rd d%0d w%0d", tag, d, w), q_of(d), mm[d][w]);
      end
    end
    ce_n = 1'b1;
  endtask

  initial begin
    int d, a, lo, hi, n;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ce_n = 1'b1;
    addr = '0;
    for (int i = 0; i < 3; i++) for (int w = 0; w < 64; w++) mk[i][w] = 0;
    m_reset();
    repeat (3) tick();
    check("reset q16", {16'h0, q16}, 32'h0);
    check("reset q32", q32, 32'h0);
    check("reset q8", {24'h0, q8}, 32'h0);
    check_state("reset");
    reset = 1'b0;
    tick();

    // 16-bit word assembled little-endian
    start_dl(1);
    wr_byte('h100, 'hAA);
    wr_byte('h101, 'h55);
    end_dl();
    check("t1 loaded16", 32'(loaded16), 32'h1);
    addr = 6'd0; ce_n = 1'b0; tick();
    check("t1 q16 word0", {16'h0, q16}, 32'h55AA);
    ce_n = 1'b1; tick();
    check("t2 q16 disabled", {16'h0, q16}, 32'h0);
    ce_n = 1'b0; tick();
    check("t2 q16 re-enabled", {16'h0, q16}, 32'h55AA);
    ce_n = 1'b1;

    // 32-bit partial word flushed with zero fill
    start_dl(2);
    wr_byte('h400, 'h11);
    wr_byte('h401, 'h22);
    wr_byte('h402, 'h33);
    end_dl();
    addr = 6'd0; ce_n = 1'b0; tick();
    check("t3 q32 flushed partial", q32, 32'h00332211);
    ce_n = 1'b1;
    check_state("t3");

    // out-of-range and wrong-index bytes leave RAM alone
    start_dl(1);
    wr_byte('h0FF, 'h99);
    wr_byte('h180, 'h98);
    ioctl_index = 8'd7;
    wr_byte('h100, 'h97);
    ioctl_index = 8'd1;
    end_dl();
    start_dl(9);
    wr_byte('h100, 'h96);
    wr_byte('h400, 'h95);
    wr_byte('h800, 'h94);
    check_state("t4 foreign download");
    end_dl();
    check_state("t4");
    sweep("t4");

    // reset in the middle of a word discards it
    start_dl(2);
    wr_byte('h400, 'h44);
    wr_byte('h401, 'h55);
    wr_byte('h402, 'h66);
    #2 reset = 1'b1;
    ioctl_download = 1'b0;
    m_reset();
    #1;
    check("t5 loaded32 in reset", 32'(loaded32), 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_state("t5 after reset");
    addr = 6'd0; ce_n = 1'b0; tick();
    check("t5 word kept", q32, 32'h00332211);
    ce_n = 1'b1;
    start_dl(2);
    wr_byte('h400, 'hA1);
    wr_byte('h401, 'hB2);
    wr_byte('h402, 'hC3);
    wr_byte('h403, 'hD4);
    end_dl();
    addr = 6'd0; ce_n = 1'b0; tick();
    check("t5 reload", q32, 32'hD4C3B2A1);
    ce_n = 1'b1;
    check_state("t5 reload");

    // byte sum, restarted by the next download
    start_dl(1);
    wr_byte('h100, 'h01);
    wr_byte('h101, 'h02);
    wr_byte('h102, 'hFF);
    wr_byte('h103, 'hFF);
    end_dl();
`ifdef DL_ROM_CHECKSUM_EN
    check("t6 checksum", 32'(cs16), 32'h0201);
`endif
    check_state("t6 first");
    start_dl(1);
    wr_byte('h104, 'h10);
    end_dl();
`ifdef DL_ROM_CHECKSUM_EN
    check("t6 checksum restart", 32'(cs16), 32'h0010);
`endif
    check_state("t6 second");
    sweep("t6");

    // random downloads with jumps, gaps and stray addresses
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 2);
      lo = base_m[d];
      hi = base_m[d] + bytes_m[d] * 64;
      start_dl(($urandom_range(0, 5) == 0) ? 9 : idx_m[d]);
      a = $urandom_range(lo, hi - 1);
      n = $urandom_range(10, 60);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) a = $urandom_range(lo - 4, hi + 3);
        wr_byte(a, $urandom_range(0, 255));
        a = a + 1;
        if (a >= hi + 4) a = lo;
        repeat ($urandom_range(0, 2)) tick();
      end
      end_dl();
      check_state($sformatf("rnd%0d", r));
      sweep($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
